// File: rtl/output_arbiter.sv
// Per-output-port switch allocator: round-robin grant held from bop to eop,
// with the granted input streamed through a one-deep registered valid/ready stage.
module output_arbiter #(
  parameter int DATA_WIDTH      = 70,
  parameter int NUMBER_CHANNELS = 5,
  parameter int PTR_W           = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUMBER_CHANNELS-1:0]            req,
  input  logic [NUMBER_CHANNELS-1:0]            in_val,
  input  logic [NUMBER_CHANNELS*DATA_WIDTH-1:0] din,
  output logic [NUMBER_CHANNELS-1:0]            rd,
  output logic [NUMBER_CHANNELS-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]                 dout,
  output logic                                  out_val,
  input  logic                                  out_ready,
  output logic                                  busy
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                     state_q, state_d;
  logic [NUMBER_CHANNELS-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]           g_q, g_d;
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]      dout_q;
  logic                       out_val_q;

  logic                       pick_vld;
  logic [PTR_W-1:0]           pick_idx;
  int                         idx;
  logic [DATA_WIDTH-1:0]      cur_flit;
  logic                       pop, eop_pop;

  // First requester at or above rr_ptr, wrapping past the last channel.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 0; k < NUMBER_CHANNELS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUMBER_CHANNELS) idx = idx - NUMBER_CHANNELS;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(idx);
      end
    end
  end

  assign cur_flit = din[int'(g_q)*DATA_WIDTH +: DATA_WIDTH];
  assign pop      = (state_q == LOCKED) && in_val[g_q] && (!out_val_q || out_ready);
  assign eop_pop  = pop && cur_flit[DATA_WIDTH-2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      g_q      <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      g_q      <= g_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    g_d      = g_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOCKED;
          g_d     = pick_idx;
          gnt_d   = NUMBER_CHANNELS'(1) << pick_idx;
        end
      end
      LOCKED: begin
        // Other requests are ignored until the eop flit leaves the input buffer.
        if (eop_pop) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = (g_q == PTR_W'(NUMBER_CHANNELS-1)) ? '0 : g_q + PTR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd = '0;
    if (pop) rd[g_q] = 1'b1;
    busy = (state_q == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q    <= '0;
      out_val_q <= 1'b0;
    end else if (pop) begin
      dout_q    <= cur_flit;
      out_val_q <= 1'b1;
    end else if (out_ready) begin
      out_val_q <= 1'b0;
    end
  end

  assign gnt     = gnt_q;
  assign dout    = dout_q;
  assign out_val = out_val_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: per-cycle vector table plus an
// off-edge asynchronous reset sequence.
module tb_output_arbiter;

  localparam int N  = 5;
  localparam int DW = 70;

  logic            clk, rst, out_ready, out_val, busy;
  logic [N-1:0]    req, in_val, rd, gnt;
  logic [N*DW-1:0] din;
  logic [DW-1:0]   dout;

  int checks = 0;
  int errors = 0;

  output_arbiter #(.DATA_WIDTH(DW), .NUMBER_CHANNELS(N), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .in_val(in_val), .din(din),
    .rd(rd), .gnt(gnt), .dout(dout), .out_val(out_val),
    .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  inv;
    logic          ordy;
    int            fch;
    logic [DW-1:0] flit;
    logic [N-1:0]  egnt;
    logic [N-1:0]  erd;
    logic          eov;
    logic [DW-1:0] edout;
    logic          ebusy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] f(input logic b, input logic e, input int t);
    return {b, e, 68'(t)};
  endfunction

  // Non-selected channels carry distinct non-eop junk so a wrong mux shows up.
  function automatic logic [DW-1:0] junk(input int i);
    return {2'b00, 68'(32'hDEAD0 + i)};
  endfunction

  task automatic add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] iv,
                     input logic ordy, input int fch, input logic [DW-1:0] fl,
                     input logic [N-1:0] eg, input logic [N-1:0] er, input logic eov,
                     input logic [DW-1:0] ed, input logic eb);
    vec_t v;
    v.rst = r; v.req = rq; v.inv = iv; v.ordy = ordy; v.fch = fch; v.flit = fl;
    v.egnt = eg; v.erd = er; v.eov = eov; v.edout = ed; v.ebusy = eb;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] iv,
                       input logic ordy, input int fch, input logic [DW-1:0] fl);
    rst = r; req = rq; in_val = iv; out_ready = ordy;
    for (int i = 0; i < N; i++) din[i*DW +: DW] = (i == fch) ? fl : junk(i);
  endtask

  task automatic chk(input string name, input int row, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    int n;
    // rst req inv ordy fch flit | gnt rd out_val dout busy
    add(0, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 0, '0,          0);
    add(1, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 0, '0,          0);
    // single requester ch1, 3-flit packet
    add(1, 5'b00010, 5'b00010, 1, 1, f(1,0,1),    5'b00000, 5'b00000, 0, '0,          0);
    add(1, 5'b00010, 5'b00010, 1, 1, f(1,0,1),    5'b00010, 5'b00010, 0, '0,          1);
    add(1, 5'b00010, 5'b00010, 1, 1, f(0,0,2),    5'b00010, 5'b00010, 1, f(1,0,1),    1);
    add(1, 5'b00010, 5'b00010, 1, 1, f(0,1,3),    5'b00010, 5'b00010, 1, f(0,0,2),    1);
    add(1, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 1, f(0,1,3),    0);
    add(1, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 0, f(0,1,3),    0);
    // reset mid-packet with out_val high
    add(1, 5'b00100, 5'b00100, 1, 2, f(1,0,10),   5'b00000, 5'b00000, 0, f(0,1,3),    0);
    add(1, 5'b00100, 5'b00100, 1, 2, f(1,0,10),   5'b00100, 5'b00100, 0, f(0,1,3),    1);
    add(0, 5'b00100, 5'b00100, 1, 2, f(0,0,11),   5'b00000, 5'b00000, 0, '0,          0);
    add(1, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 0, '0,          0);
    // round robin from rr_ptr=0, req=10011 single-flit packets: ch0, ch1, ch4, ch0
    add(1, 5'b10011, 5'b10011, 1, 0, f(1,1,20),   5'b00000, 5'b00000, 0, '0,          0);
    add(1, 5'b10011, 5'b10011, 1, 0, f(1,1,20),   5'b00001, 5'b00001, 0, '0,          1);
    add(1, 5'b10011, 5'b10011, 1, 1, f(1,1,21),   5'b00000, 5'b00000, 1, f(1,1,20),   0);
    add(1, 5'b10011, 5'b10011, 1, 1, f(1,1,21),   5'b00010, 5'b00010, 0, f(1,1,20),   1);
    add(1, 5'b10011, 5'b10011, 1, 4, f(1,1,22),   5'b00000, 5'b00000, 1, f(1,1,21),   0);
    add(1, 5'b10011, 5'b10011, 1, 4, f(1,1,22),   5'b10000, 5'b10000, 0, f(1,1,21),   1);
    add(1, 5'b10011, 5'b10011, 1, 0, f(1,1,23),   5'b00000, 5'b00000, 1, f(1,1,22),   0);
    add(1, 5'b10011, 5'b10011, 1, 0, f(1,1,23),   5'b00001, 5'b00001, 0, f(1,1,22),   1);
    add(1, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 1, f(1,1,23),   0);
    // lock hold: ch2 4-flit, req[2] drops and req[0] rises after flit 2
    add(1, 5'b00100, 5'b00100, 1, 2, f(1,0,30),   5'b00000, 5'b00000, 0, f(1,1,23),   0);
    add(1, 5'b00100, 5'b00100, 1, 2, f(1,0,30),   5'b00100, 5'b00100, 0, f(1,1,23),   1);
    add(1, 5'b00100, 5'b00100, 1, 2, f(0,0,31),   5'b00100, 5'b00100, 1, f(1,0,30),   1);
    add(1, 5'b00001, 5'b00101, 1, 2, f(0,0,32),   5'b00100, 5'b00100, 1, f(0,0,31),   1);
    add(1, 5'b00001, 5'b00101, 1, 2, f(0,1,33),   5'b00100, 5'b00100, 1, f(0,0,32),   1);
    add(1, 5'b00001, 5'b00101, 1, 0, f(1,1,34),   5'b00000, 5'b00000, 1, f(0,1,33),   0);
    add(1, 5'b00001, 5'b00101, 1, 0, f(1,1,34),   5'b00001, 5'b00001, 0, f(0,1,33),   1);
    add(1, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 1, f(1,1,34),   0);
    // backpressure 3 cycles, then a 2-cycle in_val bubble on ch3
    add(1, 5'b01000, 5'b01000, 1, 3, f(1,0,40),   5'b00000, 5'b00000, 0, f(1,1,34),   0);
    add(1, 5'b01000, 5'b01000, 1, 3, f(1,0,40),   5'b01000, 5'b01000, 0, f(1,1,34),   1);
    add(1, 5'b01000, 5'b01000, 0, 3, f(0,0,41),   5'b01000, 5'b00000, 1, f(1,0,40),   1);
    add(1, 5'b01000, 5'b01000, 0, 3, f(0,0,41),   5'b01000, 5'b00000, 1, f(1,0,40),   1);
    add(1, 5'b01000, 5'b01000, 0, 3, f(0,0,41),   5'b01000, 5'b00000, 1, f(1,0,40),   1);
    add(1, 5'b01000, 5'b01000, 1, 3, f(0,0,41),   5'b01000, 5'b01000, 1, f(1,0,40),   1);
    add(1, 5'b01000, 5'b00000, 1, 3, f(0,1,42),   5'b01000, 5'b00000, 1, f(0,0,41),   1);
    add(1, 5'b01000, 5'b00000, 1, 3, f(0,1,42),   5'b01000, 5'b00000, 0, f(0,0,41),   1);
    add(1, 5'b01000, 5'b01000, 1, 3, f(0,1,42),   5'b01000, 5'b01000, 0, f(0,0,41),   1);
    add(1, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 1, f(0,1,42),   0);
    add(1, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 0, f(0,1,42),   0);
    // rr_ptr=4 wraps: req=00011 grants ch0
    add(1, 5'b00011, 5'b00011, 1, 0, f(1,1,50),   5'b00000, 5'b00000, 0, f(0,1,42),   0);
    add(1, 5'b00011, 5'b00011, 1, 0, f(1,1,50),   5'b00001, 5'b00001, 0, f(0,1,42),   1);
    add(1, 5'b00000, 5'b00000, 1, 0, '0,          5'b00000, 5'b00000, 1, f(1,1,50),   0);

    drive(0, '0, '0, 1, 0, '0);
    repeat (2) @(posedge clk);

    foreach (tbl[r]) begin
      @(negedge clk);
      drive(tbl[r].rst, tbl[r].req, tbl[r].inv, tbl[r].ordy, tbl[r].fch, tbl[r].flit);
      #1;
      chk("gnt",     r, DW'(gnt),     DW'(tbl[r].egnt));
      chk("rd",      r, DW'(rd),      DW'(tbl[r].erd));
      chk("out_val", r, DW'(out_val), DW'(tbl[r].eov));
      chk("dout",    r, dout,         tbl[r].edout);
      chk("busy",    r, DW'(busy),    DW'(tbl[r].ebusy));
    end

    // Reset asserted off-edge mid-packet must clear outputs without a clock edge.
    @(negedge clk);
    drive(1, 5'b00100, 5'b00100, 1, 2, f(1,0,60));
    n = 0;
    while (gnt === '0 && n < 4) begin
      @(posedge clk); #1; n++;
    end
    chk("hs_gnt", 100, DW'(gnt), DW'(5'b00100));
    @(posedge clk); #2;
    chk("hs_out_val", 101, DW'(out_val), DW'(1'b1));
    chk("hs_dout",    102, dout, f(1,0,60));
    rst = 1'b0;
    #1;
    chk("hs_rst_dout",    103, dout, '0);
    chk("hs_rst_out_val", 104, DW'(out_val), '0);
    chk("hs_rst_gnt",     105, DW'(gnt), '0);
    chk("hs_rst_busy",    106, DW'(busy), '0);
    @(negedge clk);
    drive(1, '0, '0, 1, 0, '0);
    @(negedge clk); #1;
    chk("hs_post_busy", 107, DW'(busy), '0);
    chk("hs_post_gnt",  108, DW'(gnt), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Per-output-port switch allocator and crossbar mux. Sits directly downstream of the NUMBER_CHANNELS input_controller instances of a router.
- Collects bit k of every input controller's one-hot req_x, where bit k is this output port, as a request vector.
- Grants one input at a time with round-robin fairness and holds the grant for a whole packet, from the bop flit to the eop flit.
- Streams the granted input's flits through a one-deep registered output stage with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 70: flit width. Bit DATA_WIDTH-1 is bop; bit DATA_WIDTH-2 is eop.
- NUMBER_CHANNELS, 5: number of input channels competing for this output. Index NUMBER_CHANNELS-1 is the local port.
- PTR_W, 3: width of the grant index and round-robin pointer. Must satisfy 2^PTR_W >= NUMBER_CHANNELS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 clears all state immediately.
- req  input  NUMBER_CHANNELS  bit i = input controller i requests this output.
- in_val  input  NUMBER_CHANNELS  bit i = input buffer i presents a valid flit.
- din  input  NUMBER_CHANNELS*DATA_WIDTH  flattened flits; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- rd  output  NUMBER_CHANNELS  one-hot pop strobe back to input buffer i.
- gnt  output  NUMBER_CHANNELS  one-hot current grant; all zeros when idle.
- dout  output  DATA_WIDTH  registered output flit.
- out_val  output  1  dout valid.
- out_ready  input  1  downstream accepts dout this cycle.
- busy  output  1  high while a packet is locked.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, gnt=0, rd=0, dout=0, out_val=0, busy=0, rr_ptr=0.
  - A reset mid-packet drops the packet. Nothing resumes after reset is released.
- State machine:
  - IDLE:
    - If req != 0, select the first set bit of req searching upward from rr_ptr, wrapping from NUMBER_CHANNELS-1 to 0.
    - Register the one-hot gnt and the index g; next state LOCKED.
    - If req == 0, remain IDLE.
    - Arbitration latency is 1 cycle from req to gnt.
  - LOCKED:
    - rd[g] = in_val[g] & (~out_val | out_ready). rd is combinational and zero for every other channel.
    - On rd[g]: dout <= din[g] and out_val <= 1.
    - Otherwise, if out_ready, out_val <= 0.
    - If rd[g] and din[g] has eop=1: next state IDLE, gnt cleared, rr_ptr <= g+1 (wrapping to 0 after NUMBER_CHANNELS-1).
- Lock rule:
  - Once granted, the lock holds until the eop flit is popped.
  - Deassertion of req[g] mid-packet is ignored.
  - Requests from other channels are ignored while LOCKED.
- Single-flit packets (bop=1 and eop=1): granted, popped once, and released the same way as longer packets.
- Throughput:
  - 1 flit/cycle while in_val[g] and out_ready are both high.
  - One idle bubble cycle between consecutive packets (the re-arbitration cycle).
- Backpressure:
  - out_ready=0 with out_val=1 holds dout stable and forces rd=0.
  - No flit is dropped or duplicated.
- Simultaneous events: when an eop pop coincides with new requests, the requests are considered in the following IDLE cycle against the updated rr_ptr.
- busy equals (state==LOCKED).
- gnt is fed back to the input controllers. A granted input must not change its request until eop.

Test Plan:
- Reset: drive rst=0 mid-packet with out_val=1 -> dout=0, out_val=0, gnt=0 immediately; after release, state is IDLE and rr_ptr=0.
- Single requester: req=5'b00010; 3-flit packet on ch1 (bop, body, eop) with out_ready=1 -> gnt=00010 one cycle later; three consecutive rd[1] pulses; dout shows the 3 flits in order; gnt returns to 0 the cycle after the eop pop.
- Round-robin: req=5'b10011 held constant, each channel sending 1-flit packets -> grant order ch0, ch1, ch4, ch0; exactly one bubble cycle between grants.
- Lock hold: ch2 granted on a 4-flit packet; req[0] asserts and req[2] drops after flit 2 -> all 4 ch2 flits are delivered before ch0 is granted.
- Backpressure: out_ready=0 for 3 cycles after the first flit -> dout and out_val stable, rd=0 throughout; on resume, the remaining flits are delivered with no loss or duplication.
- Bubbles: in_val[g]=0 for 2 cycles mid-packet -> rd[g]=0 and out_val falls after acceptance; the lock is retained and the packet completes on resume.
